// File: rtl/soc_pio_pkg.sv
// Shared definitions for the pulse-capable output PIO: register map,
// CTRL/STATUS bit positions and the pulse engine state encoding.
package soc_pio_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_OUTSET     = 3'd1;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE     = 3'd3;
    localparam logic [2:0] ADDR_PULSE_MASK = 3'd4;
    localparam logic [2:0] ADDR_PULSE_LEN  = 3'd5;
    localparam logic [2:0] ADDR_CTRL       = 3'd6;
    localparam logic [2:0] ADDR_STATUS     = 3'd7;

    localparam int CTRL_START   = 0;
    localparam int CTRL_REPEAT  = 1;
    localparam int CTRL_STOP    = 2;
    localparam int CTRL_IRQ_EN  = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERLAY = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } pulse_state_t;

endpackage

// File: rtl/soc_pio_pulse_timer.sv
// Pulse/blink engine: ON/OFF phase FSM driven by a down-counter that is
// reloaded from len at every phase start.
module soc_pio_pulse_timer
    import soc_pio_pkg::*;
#(
    parameter int TIMER_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   repeat_en,
    input  logic [TIMER_WIDTH-1:0] len,
    output logic                   overlay_on,
    output logic                   busy,
    output logic                   done_pulse
);

    pulse_state_t           state_reg, state_next;
    logic [TIMER_WIDTH-1:0] count_reg, count_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        done_pulse = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else if (start && (len != '0)) begin
            state_next = ST_ON;
            count_next = len;
        end else begin
            case (state_reg)
                ST_IDLE: ;
                ST_ON: begin
                    if (count_reg <= TIMER_WIDTH'(1)) begin
                        // A len rewritten to zero mid-run ends the run rather than wrapping.
                        if (repeat_en && (len != '0)) begin
                            state_next = ST_OFF;
                            count_next = len;
                        end else begin
                            state_next = ST_IDLE;
                            count_next = '0;
                            done_pulse = 1'b1;
                        end
                    end else begin
                        count_next = count_reg - TIMER_WIDTH'(1);
                    end
                end
                ST_OFF: begin
                    if (count_reg <= TIMER_WIDTH'(1)) begin
                        done_pulse = 1'b1;
                        if (len != '0) begin
                            state_next = ST_ON;
                            count_next = len;
                        end else begin
                            state_next = ST_IDLE;
                            count_next = '0;
                        end
                    end else begin
                        count_next = count_reg - TIMER_WIDTH'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    assign overlay_on = (state_reg == ST_ON);
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: rtl/soc_pio_output_pulse.sv
// Avalon-MM output PIO with atomic set/clear/toggle and a pulse/blink
// engine that XORs a mask onto out_port.
module soc_pio_output_pulse
    import soc_pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          TIMER_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0]  data_reg, mask_reg, wd_data;
    logic [TIMER_WIDTH-1:0] len_reg;
    logic                   repeat_reg, irq_en_reg, done_reg;
    logic                   wr, start, stop, overlay_on, busy, done_pulse;
    logic [31:0]            rd_data;
    logic                   unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_data   = writedata[DATA_WIDTH-1:0];
    assign start     = wr && (address == ADDR_CTRL) && writedata[CTRL_START];
    assign stop      = wr && (address == ADDR_CTRL) && writedata[CTRL_STOP];
    assign unused_wd = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg   <= RESET_VALUE[DATA_WIDTH-1:0];
            mask_reg   <= '0;
            len_reg    <= '0;
            repeat_reg <= 1'b0;
            irq_en_reg <= 1'b0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:       data_reg <= wd_data;
                ADDR_OUTSET:     data_reg <= data_reg | wd_data;
                ADDR_OUTCLEAR:   data_reg <= data_reg & ~wd_data;
                ADDR_TOGGLE:     data_reg <= data_reg ^ wd_data;
                ADDR_PULSE_MASK: mask_reg <= wd_data;
                ADDR_PULSE_LEN:  len_reg  <= writedata[TIMER_WIDTH-1:0];
                ADDR_CTRL: begin
                    repeat_reg <= writedata[CTRL_REPEAT];
                    irq_en_reg <= writedata[CTRL_IRQ_EN];
                end
                default: ;
            endcase
        end
    end

    // A completion in the same cycle as a W1C keeps DONE set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_reg <= 1'b0;
        end else if (done_pulse) begin
            done_reg <= 1'b1;
        end else if (wr && (address == ADDR_STATUS) && writedata[STAT_DONE]) begin
            done_reg <= 1'b0;
        end
    end

    soc_pio_pulse_timer #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .repeat_en  (repeat_reg),
        .len        (len_reg),
        .overlay_on (overlay_on),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
            assign out_port[gi] = data_reg[gi] ^ (overlay_on & mask_reg[gi]);
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR, ADDR_TOGGLE:
                rd_data[DATA_WIDTH-1:0] = data_reg;
            ADDR_PULSE_MASK: rd_data[DATA_WIDTH-1:0]  = mask_reg;
            ADDR_PULSE_LEN:  rd_data[TIMER_WIDTH-1:0] = len_reg;
            ADDR_CTRL: begin
                rd_data[CTRL_REPEAT] = repeat_reg;
                rd_data[CTRL_IRQ_EN] = irq_en_reg;
            end
            ADDR_STATUS: begin
                rd_data[STAT_BUSY]    = busy;
                rd_data[STAT_DONE]    = done_reg;
                rd_data[STAT_OVERLAY] = overlay_on;
            end
            default: ;
        endcase
    end

    assign readdata = rd_data;
    assign irq      = done_reg & irq_en_reg;

endmodule

// File: doc/soc_pio_output_pulse.md
Name: soc_pio_output_pulse

Overview:
- Parametrised successor to the single-register Avalon-MM output PIO.
- Provides an output port of configurable width, with atomic set/clear/toggle writes and a hardware pulse/blink engine that XORs a mask onto the port for a programmed number of cycles.
- The engine can run one-shot or repeating (traffic-light blink), with a done interrupt.
- Sits on the HPS lightweight bridge as an Avalon-MM slave; out_port drives lamp/GPIO logic.

Parameters:
- DATA_WIDTH, 32, output port width, legal range 1..32.
- RESET_VALUE, 0, DATA register value after reset.
- TIMER_WIDTH, 24, width of PULSE_LEN register and down-counter, legal range 1..32.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; only the low DATA_WIDTH (or TIMER_WIDTH) bits are used.
- readdata  out  32  combinational read data, zero-extended; read latency 0.
- out_port  out  DATA_WIDTH  data ^ (overlay_on ? pulse_mask : 0).
- irq  out  1  level interrupt = done_flag & irq_en.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Reads have no side effects.
- Register map:
  - 0 DATA (RW)
  - 1 OUTSET (W; data |= wd; reads DATA)
  - 2 OUTCLEAR (W; data &= ~wd; reads DATA)
  - 3 TOGGLE (W; data ^= wd; reads DATA)
  - 4 PULSE_MASK (RW)
  - 5 PULSE_LEN (RW, cycles)
  - 6 CTRL: bit0 START (W1, self-clearing, reads 0), bit1 REPEAT (RW), bit2 STOP (W1, reads 0), bit3 IRQ_EN (RW)
  - 7 STATUS: bit0 BUSY (RO), bit1 DONE (sticky; write 1 to clear), bit2 OVERLAY_ON (RO)
- Reset values:
  - data = RESET_VALUE; pulse_mask = 0; pulse_len = 0; REPEAT = 0; IRQ_EN = 0; DONE = 0.
  - FSM in IDLE, counter = 0.
  - out_port = RESET_VALUE; irq = 0; readdata reflects these values.
- FSM states:
  - IDLE: overlay off, BUSY = 0.
  - ON: overlay on, BUSY = 1.
  - OFF: overlay off, BUSY = 1; entered only when REPEAT = 1.
- Transitions:
  - IDLE --START & pulse_len != 0--> ON, counter <= pulse_len. Overlay is visible on out_port from the cycle after the write edge.
  - ON: counter decrements each cycle. At counter == 1:
    - REPEAT = 0: go to IDLE and set DONE.
    - REPEAT = 1: go to OFF, counter <= pulse_len.
    - ON therefore lasts exactly pulse_len cycles.
  - OFF: decrements likewise; at counter == 1 go to ON with a reload. Sets DONE on each completed ON+OFF period.
  - STOP in any state: go to IDLE next edge, overlay off, DONE unchanged.
- Boundary conditions:
  - START with pulse_len == 0: ignored; stays IDLE, DONE not set.
  - START while BUSY: restart in ON with the counter reloaded from the current pulse_len.
  - START and STOP in the same write: STOP wins.
  - Writing PULSE_LEN while BUSY: affects the next reload only. Writing PULSE_MASK while BUSY: takes effect immediately on out_port.
  - DATA/SET/CLR/TOGGLE writes while BUSY: update data immediately; the overlay continues on top.
  - DONE set and a W1C on the same cycle: set wins, DONE stays 1.
  - Clearing REPEAT while in OFF: the current OFF completes, then ON runs once, then IDLE with DONE set.
  - Width truncation: pulse_len = wd[TIMER_WIDTH-1:0]; mask/data use wd[DATA_WIDTH-1:0].
  - Asserting reset mid-pulse: everything returns to reset values asynchronously.
  - Unused read bits return 0.

Decomposition:
- Shared package soc_pio_pkg holds:
  - register address constants (ADDR_DATA..ADDR_STATUS);
  - CTRL/STATUS bit indices;
  - the FSM state encoding (IDLE = 2'd0, ON = 2'd1, OFF = 2'd2).
- One sub-module: soc_pio_pulse_timer, containing the FSM and the TIMER_WIDTH down-counter.
  - Inputs: start, stop, repeat, len.
  - Outputs: overlay_on, busy, done_pulse.
- The register file and read mux stay in the top level.

Test Plan:
- Reset with RESET_VALUE = 32'h0000_00A5 -> out_port = 0xA5, irq = 0, STATUS = 0; DATA reads 0xA5.
- Bitwise register writes, starting from DATA = 0xF0:
  - OUTSET 0x0F -> 0xFF.
  - OUTCLEAR 0x81 -> 0x7E.
  - TOGGLE 0xFF -> 0x81.
  - out_port updates the cycle after each write.
- One-shot pulse: MASK = 0x3, LEN = 5, IRQ_EN = 1, START with DATA = 0x0 -> out_port = 0x3 for exactly 5 cycles, then 0x0. DONE = 1 and irq = 1; W1C on DONE -> irq = 0.
- Repeat blink: LEN = 3, REPEAT = 1 -> out_port alternates 3 cycles ON / 3 cycles OFF for 4 periods. STOP mid-ON -> overlay off the next cycle and BUSY = 0.
- Edge starts:
  - LEN = 0 + START -> BUSY stays 0, DONE stays 0.
  - START twice, 2 cycles apart, with LEN = 4 -> ON lasts 6 cycles total.
- Reset mid-pulse (reset_n low for 1 cycle at counter = 2) -> out_port = RESET_VALUE immediately; all registers reset; no DONE.
